// File: rtl/zbuf_pkg.sv
// Shared types for the span scheduler: FSM state encoding and the
// {x,y,z} point layout used on every 24-bit point bus.
package zbuf_pkg;

    localparam int PT_W = 24;

    // Scheduler FSM states.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LAUNCH = 3'd1,
        ST_BUSY   = 3'd2,
        ST_DONE   = 3'd3,
        ST_ABORT  = 3'd4
    } state_t;

    // Point field layout: X=[23:16], Y=[15:8], Z=[7:0].
    typedef struct packed {
        logic [7:0] x;
        logic [7:0] y;
        logic [7:0] z;
    } point_t;

    // A span is drawable only when both end points lie on the same row.
    function automatic logic same_row(input logic [PT_W-1:0] pa, input logic [PT_W-1:0] pb);
        point_t a;
        point_t b;
        a = point_t'(pa);
        b = point_t'(pb);
        return a.y == b.y;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-port round-robin selector. A lone requester always wins; on a tie
// the port that was not granted last time wins.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       gnt_idx,
    output logic       valid
);

    // Pick the winning port index from the request pair and the last grant.
    always_comb begin
        valid   = |req;
        gnt_idx = 1'b0;
        case (req)
            2'b01:   gnt_idx = 1'b0;
            2'b10:   gnt_idx = 1'b1;
            2'b11:   gnt_idx = ~last;
            default: gnt_idx = 1'b0;
        endcase
    end

endmodule

// File: rtl/span_sched.sv
// Span scheduler: arbitrates two span requesters, holds the selected span
// for the fill engine, runs the launch/busy handshake with a timeout, and
// keeps a completed-span counter plus a sticky timeout error flag.
module span_sched
    import zbuf_pkg::*;
#(
    parameter int TIMEOUT_CYC = 1023,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_0,
    input  logic [PT_W-1:0]   pa_0,
    input  logic [PT_W-1:0]   pb_0,
    input  logic [PT_W-1:0]   rgb_0,
    input  logic              req_1,
    input  logic [PT_W-1:0]   pa_1,
    input  logic [PT_W-1:0]   pb_1,
    input  logic [PT_W-1:0]   rgb_1,
    output logic              gnt_0,
    output logic              gnt_1,
    output logic              done_0,
    output logic              done_1,
    output logic              rej_0,
    output logic              rej_1,
    output logic              req_2,
    input  logic              ack_2,
    output logic [PT_W-1:0]   point_out_a,
    output logic [PT_W-1:0]   point_out_b,
    output logic [PT_W-1:0]   rgb,
    output logic              busy,
    output logic [CNT_W-1:0]  span_cnt,
    output logic              err_timeout,
    input  logic              err_clr
);

    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

    state_t            state_reg;
    state_t            state_next;
    logic              last_grant_reg;
    logic              gidx_reg;
    logic              rej_reg;
    logic [TMO_W-1:0]  tmo_cnt_reg;
    logic [CNT_W-1:0]  span_cnt_reg;
    logic              err_reg;
    logic [PT_W-1:0]   pa_reg;
    logic [PT_W-1:0]   pb_reg;
    logic [PT_W-1:0]   rgb_reg;

    logic              arb_idx;
    logic              arb_valid;
    logic              grant;
    logic              row_ok;
    logic              tmo_hit;
    logic              abort_enter;
    logic [PT_W-1:0]   sel_pa;
    logic [PT_W-1:0]   sel_pb;
    logic [PT_W-1:0]   sel_rgb;

    rr_arb2 u_arb (
        .req     ({req_1, req_0}),
        .last    (last_grant_reg),
        .gnt_idx (arb_idx),
        .valid   (arb_valid)
    );

    // Grant is combinational in IDLE; it is masked while reset is held so
    // that every response output reads 0 during reset.
    assign grant       = rst && (state_reg == ST_IDLE) && arb_valid;
    assign sel_pa      = arb_idx ? pa_1  : pa_0;
    assign sel_pb      = arb_idx ? pb_1  : pb_0;
    assign sel_rgb     = arb_idx ? rgb_1 : rgb_0;
    assign row_ok      = same_row(sel_pa, sel_pb);
    assign tmo_hit     = (tmo_cnt_reg == TMO_LAST);
    assign abort_enter = (state_next == ST_ABORT) && (state_reg != ST_ABORT);

    // Next-state logic for the launch / busy / done / abort sequence.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (grant && row_ok) state_next = ST_LAUNCH;
            end
            ST_LAUNCH: begin
                if (ack_2)        state_next = ST_BUSY;
                else if (tmo_hit) state_next = ST_ABORT;
            end
            ST_BUSY: begin
                if (!ack_2)       state_next = ST_DONE;
                else if (tmo_hit) state_next = ST_ABORT;
            end
            ST_DONE:  state_next = ST_IDLE;
            ST_ABORT: state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_reg <= ST_IDLE;
        else      state_reg <= state_next;
    end

    // Timeout counter: restarts on every state change, counts in LAUNCH/BUSY.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmo_cnt_reg <= '0;
        end else if (state_next != state_reg) begin
            tmo_cnt_reg <= '0;
        end else if (state_reg == ST_LAUNCH || state_reg == ST_BUSY) begin
            tmo_cnt_reg <= tmo_cnt_reg + TMO_W'(1);
        end
    end

    // Latch the winning job, remember who won, and flag a row mismatch.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pa_reg         <= '0;
            pb_reg         <= '0;
            rgb_reg        <= '0;
            gidx_reg       <= 1'b0;
            last_grant_reg <= 1'b1;
            rej_reg        <= 1'b0;
        end else begin
            rej_reg <= grant && !row_ok;
            if (grant) begin
                pa_reg         <= sel_pa;
                pb_reg         <= sel_pb;
                rgb_reg        <= sel_rgb;
                gidx_reg       <= arb_idx;
                last_grant_reg <= arb_idx;
            end
        end
    end

    // Completed-span counter, advanced once per DONE; wraps naturally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                      span_cnt_reg <= '0;
        else if (state_reg == ST_DONE) span_cnt_reg <= span_cnt_reg + CNT_W'(1);
    end

    // Sticky timeout flag; a new timeout beats a simultaneous clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)             err_reg <= 1'b0;
        else if (abort_enter) err_reg <= 1'b1;
        else if (err_clr)     err_reg <= 1'b0;
    end

    assign gnt_0       = grant && !arb_idx;
    assign gnt_1       = grant &&  arb_idx;
    assign done_0      = (state_reg == ST_DONE || state_reg == ST_ABORT) && !gidx_reg;
    assign done_1      = (state_reg == ST_DONE || state_reg == ST_ABORT) &&  gidx_reg;
    assign rej_0       = rej_reg && !gidx_reg;
    assign rej_1       = rej_reg &&  gidx_reg;
    assign req_2       = (state_reg == ST_LAUNCH);
    assign busy        = (state_reg != ST_IDLE);
    assign point_out_a = pa_reg;
    assign point_out_b = pb_reg;
    assign rgb         = rgb_reg;
    assign span_cnt    = span_cnt_reg;
    assign err_timeout = err_reg;

endmodule

// File: tb/tb_span_sched.sv
// Bench for span_sched: directed vector table, timeout / reset / wrap
// sequences, then randomized jobs checked against a job-level model.
module tb_span_sched;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          req_0 = 1'b0, req_1 = 1'b0;
    logic [23:0]   pa_0 = '0, pb_0 = '0, rgb_0 = '0;
    logic [23:0]   pa_1 = '0, pb_1 = '0, rgb_1 = '0;
    logic          gnt_0, gnt_1, done_0, done_1, rej_0, rej_1;
    logic          req_2;
    logic          ack_2 = 1'b0;
    logic [23:0]   point_out_a, point_out_b, rgb;
    logic          busy;
    logic [CW-1:0] span_cnt;
    logic          err_timeout;
    logic          err_clr = 1'b0;

    span_sched #(.TIMEOUT_CYC(1023), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .req_0(req_0), .pa_0(pa_0), .pb_0(pb_0), .rgb_0(rgb_0),
        .req_1(req_1), .pa_1(pa_1), .pb_1(pb_1), .rgb_1(rgb_1),
        .gnt_0(gnt_0), .gnt_1(gnt_1), .done_0(done_0), .done_1(done_1),
        .rej_0(rej_0), .rej_1(rej_1),
        .req_2(req_2), .ack_2(ack_2),
        .point_out_a(point_out_a), .point_out_b(point_out_b), .rgb(rgb),
        .busy(busy), .span_cnt(span_cnt), .err_timeout(err_timeout), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int job_no = 0;

    // Job-level reference state: who won last, how many spans completed.
    int model_last = 1;
    int model_cnt  = 0;

    typedef struct {
        logic [1:0]  mask;
        logic [23:0] pa0, pb0, rgb0, pa1, pb1, rgb1;
        int          ack_dly;
        int          busy_len;
        int          exp_port;
        int          exp_rej;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h", name, got, exp);
        end
    endtask

    // One complete job: request, grant, then reject or launch/busy/done.
    task automatic run_job(input logic [1:0] mask,
                           input logic [23:0] a0, input logic [23:0] b0, input logic [23:0] c0,
                           input logic [23:0] a1, input logic [23:0] b1, input logic [23:0] c1,
                           input int ack_dly, input int busy_len,
                           output int got_port, output int got_rej);
        int          exp_port;
        int          exp_rej;
        logic [23:0] ea, eb, ec;
        logic [1:0]  onehot;
        int          waited;
        bit          ok;
        exp_port = (mask == 2'b01) ? 0 : (mask == 2'b10) ? 1 : (model_last == 1 ? 0 : 1);
        ea = (exp_port == 1) ? a1 : a0;
        eb = (exp_port == 1) ? b1 : b0;
        ec = (exp_port == 1) ? c1 : c0;
        exp_rej = (ea[15:8] != eb[15:8]) ? 1 : 0;
        onehot  = (exp_port == 1) ? 2'b10 : 2'b01;

        @(negedge clk);
        req_0 = mask[0]; req_1 = mask[1];
        pa_0 = a0; pb_0 = b0; rgb_0 = c0;
        pa_1 = a1; pb_1 = b1; rgb_1 = c1;
        #1;
        waited = 0;
        while (!(gnt_0 || gnt_1) && waited < 50) begin
            @(negedge clk); #1; waited++;
        end
        got_port = gnt_1 ? 1 : 0;
        chk("gnt", 32'({gnt_1, gnt_0}), 32'(onehot));
        model_last = exp_port;

        @(negedge clk);
        req_0 = 1'b0; req_1 = 1'b0; ack_2 = 1'b0;
        #1;
        got_rej = (rej_0 || rej_1) ? 1 : 0;
        chk("held_pa", 32'(point_out_a), 32'(ea));
        chk("held_pb", 32'(point_out_b), 32'(eb));
        chk("held_rgb", 32'(rgb), 32'(ec));
        if (exp_rej == 1) begin
            chk("rej", 32'({rej_1, rej_0}), 32'(onehot));
            chk("rej_req2", 32'(req_2), 32'd0);
            chk("rej_busy", 32'(busy), 32'd0);
            chk("rej_span_cnt", 32'(span_cnt), 32'(model_cnt));
        end else begin
            ok = 1'b1;
            for (int i = 0; i <= ack_dly; i++) begin
                if (i > 0) @(negedge clk);
                ack_2 = (i == ack_dly);
                #1;
                if (req_2 !== 1'b1 || busy !== 1'b1 || rej_0 || rej_1) ok = 1'b0;
            end
            for (int j = 0; j <= busy_len; j++) begin
                @(negedge clk);
                ack_2 = (j < busy_len);
                #1;
                if (req_2 !== 1'b0 || busy !== 1'b1 || done_0 || done_1) ok = 1'b0;
            end
            chk("launch_busy_seq", 32'(ok), 32'd1);
            @(negedge clk); #1;
            chk("done", 32'({done_1, done_0}), 32'(onehot));
            chk("done_busy", 32'(busy), 32'd1);
            @(negedge clk); #1;
            model_cnt = (model_cnt + 1) % (1 << CW);
            chk("span_cnt", 32'(span_cnt), 32'(model_cnt));
            chk("done_once", 32'({done_1, done_0}), 32'd0);
            chk("idle_busy", 32'(busy), 32'd0);
        end
        $display("job %0d: mask=%b port=%0d rej=%0d ack_dly=%0d busy_len=%0d span_cnt=%0d",
                 job_no, mask, got_port, got_rej, ack_dly, busy_len, span_cnt);
        job_no++;
    endtask

    task automatic rand_job(input bit force_ok);
        logic [23:0] a0, b0, a1, b1, c0, c1;
        logic [1:0]  mask;
        int          gp, gr;
        mask = 2'($urandom_range(3, 1));
        a0 = 24'($urandom); b0 = 24'($urandom); c0 = 24'($urandom);
        a1 = 24'($urandom); b1 = 24'($urandom); c1 = 24'($urandom);
        if (force_ok || $urandom_range(3) != 0) begin
            b0[15:8] = a0[15:8];
            b1[15:8] = a1[15:8];
        end
        run_job(mask, a0, b0, c0, a1, b1, c1,
                $urandom_range(4), $urandom_range(5), gp, gr);
    endtask

    initial begin
        int gp, gr, n, n_req2;

        vecs[0] = '{2'b11, 24'h0A3210, 24'h143220, 24'hFF8040, 24'h01AA02, 24'h05AA09, 24'h123456, 1, 2, 0, 0};
        vecs[1] = '{2'b11, 24'h0A3210, 24'h143220, 24'hFF8040, 24'h01AA02, 24'h05AA09, 24'h123456, 0, 1, 1, 0};
        vecs[2] = '{2'b11, 24'h0A3210, 24'h143220, 24'hFF8040, 24'h01AA02, 24'h05AA09, 24'h123456, 3, 0, 0, 0};
        vecs[3] = '{2'b01, 24'h0A3210, 24'h143220, 24'hFF8040, 24'h000000, 24'h000000, 24'h000000, 2, 20, 0, 0};
        vecs[4] = '{2'b01, 24'h0A3210, 24'h143320, 24'hFF8040, 24'h000000, 24'h000000, 24'h000000, 0, 0, 0, 1};
        vecs[5] = '{2'b10, 24'h000000, 24'h000000, 24'h000000, 24'h7F4401, 24'h804402, 24'hABCDEF, 1, 1, 1, 0};
        vecs[6] = '{2'b10, 24'h000000, 24'h000000, 24'h000000, 24'h001000, 24'h001100, 24'h0000FF, 0, 0, 1, 1};
        vecs[7] = '{2'b11, 24'h335566, 24'h445599, 24'h010203, 24'h220011, 24'h2200EE, 24'h0F0F0F, 0, 3, 0, 0};

        // Reset state, with a request pending that must not be granted.
        req_0 = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_gnt", 32'({gnt_1, gnt_0}), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_req2", 32'(req_2), 32'd0);
        chk("rst_outs", 32'({done_1, done_0, rej_1, rej_0, err_timeout}), 32'd0);
        chk("rst_pa", 32'(point_out_a), 32'd0);
        chk("rst_span_cnt", 32'(span_cnt), 32'd0);
        @(negedge clk);
        req_0 = 1'b0;
        rst = 1'b1;

        // Directed vector table.
        for (int i = 0; i < 8; i++) begin
            run_job(vecs[i].mask, vecs[i].pa0, vecs[i].pb0, vecs[i].rgb0,
                    vecs[i].pa1, vecs[i].pb1, vecs[i].rgb1,
                    vecs[i].ack_dly, vecs[i].busy_len, gp, gr);
            chk("vec_port", 32'(gp), 32'(vecs[i].exp_port));
            chk("vec_rej", 32'(gr), 32'(vecs[i].exp_rej));
        end

        // Timeout: fill engine never acknowledges.
        @(negedge clk);
        req_0 = 1'b1; pa_0 = 24'h0A3210; pb_0 = 24'h143220; rgb_0 = 24'hFF8040;
        #1;
        chk("tmo_gnt", 32'({gnt_1, gnt_0}), 32'b01);
        model_last = 0;
        @(negedge clk);
        req_0 = 1'b0; ack_2 = 1'b0;
        #1;
        n = 0; n_req2 = 0;
        while (!done_0 && n < 1100) begin
            if (req_2) n_req2++;
            @(negedge clk); #1; n++;
        end
        chk("tmo_done", 32'(done_0), 32'd1);
        chk("tmo_launch_cycles", 32'(n_req2), 32'd1023);
        chk("tmo_abort_req2", 32'(req_2), 32'd0);
        @(negedge clk); #1;
        chk("tmo_err_set", 32'(err_timeout), 32'd1);
        chk("tmo_span_cnt", 32'(span_cnt), 32'(model_cnt));
        chk("tmo_idle", 32'(busy), 32'd0);
        $display("timeout: launch_cycles=%0d err_timeout=%0d", n_req2, err_timeout);
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        #1;
        chk("err_clr", 32'(err_timeout), 32'd0);

        // Reset asserted while the fill engine is busy.
        @(negedge clk);
        req_0 = 1'b1; pa_0 = 24'h112233; pb_0 = 24'h442299; rgb_0 = 24'h5A5A5A;
        #1;
        chk("rb_gnt", 32'({gnt_1, gnt_0}), 32'b01);
        @(negedge clk);
        req_0 = 1'b0; ack_2 = 1'b1;
        @(negedge clk); #1;
        chk("rb_in_busy", 32'({busy, req_2}), 32'b10);
        #2;
        rst = 1'b0;
        #1;
        chk("rb_busy", 32'(busy), 32'd0);
        chk("rb_outs", 32'({req_2, done_1, done_0, rej_1, rej_0}), 32'd0);
        chk("rb_points", 32'(point_out_a | point_out_b | rgb), 32'd0);
        chk("rb_span_cnt", 32'(span_cnt), 32'd0);
        n = 0;
        repeat (3) begin
            @(negedge clk); #1;
            if (done_0 || done_1 || busy) n++;
        end
        chk("rb_no_done", 32'(n), 32'd0);
        ack_2 = 1'b0;
        rst = 1'b1;
        model_last = 1;
        model_cnt  = 0;
        run_job(2'b01, 24'h112233, 24'h442299, 24'h5A5A5A, 24'h0, 24'h0, 24'h0, 1, 1, gp, gr);

        // Counter wrap: 15 more completions bring a 4-bit count back to 0.
        for (int k = 0; k < 15; k++) rand_job(1'b1);
        chk("wrap", 32'(span_cnt), 32'd0);

        // Randomized jobs against the model.
        for (int k = 0; k < 40; k++) rand_job(1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog so the bench always terminates.
    initial begin
        #2000000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
